// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch-stage branch predictor:
// branch opcode, 2-bit counter states and B-immediate extraction.
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_RST = CNT_WNT;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic cnt_e cnt_step(input cnt_e cnt, input logic taken);
        cnt_e nxt;
        nxt = cnt;
        unique case (cnt)
            CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
            default: nxt = CNT_RST;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: async read, sync update, sync reset.
module bp_counter_table
    import riscv_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int DEPTH = 1 << IDX_BITS;

    cnt_e cnt_q [DEPTH];
    cnt_e cnt_d [DEPTH];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = cnt_step(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_RST;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the old counter.
    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage 2-bit branch predictor with D/E/M tracking queue.
// Optional GSHARE_PREDICTOR_EN xors a global history into the index.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0] pc_M,
    input  logic                  pcsrc,
    input  logic                  load_use_flag,
    input  logic                  miss,
    output logic                  pre_branch,
    output logic                  prediction,
    output logic [DATA_WIDTH-1:0] label,
    output logic                  correct,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] new_label
);

    logic [IDX_BITS-1:0] if_idx;
    logic [1:0]          rd_cnt;
    logic                wr_en;
    logic                flush;
    logic                unused_instr;

    logic                d_vld_q, d_vld_d;
    logic                e_vld_q, e_vld_d;
    logic                m_vld_q, m_vld_d;
    logic                d_pred_q, d_pred_d;
    logic                e_pred_q, e_pred_d;
    logic                m_pred_q, m_pred_d;
    logic [IDX_BITS-1:0] d_idx_q, d_idx_d;
    logic [IDX_BITS-1:0] e_idx_q, e_idx_d;
    logic [IDX_BITS-1:0] m_idx_q, m_idx_d;

`ifdef GSHARE_PREDICTOR_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    assign if_idx = pc[IDX_BITS+1:2] ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (wr_en) begin
            ghr_d = {ghr_q[IDX_BITS-2:0], pcsrc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign if_idx = pc[IDX_BITS+1:2];
`endif

    assign unused_instr = ^instr[24:12];

    assign pre_branch = (instr[6:0] == OPC_BRANCH);
    assign prediction = rd_cnt[1] & pre_branch;
    assign label      = pc + DATA_WIDTH'($signed(b_imm(instr[31:0])));

    assign correct   = m_vld_q & (m_pred_q == pcsrc);
    assign error     = m_vld_q & m_pred_q & ~pcsrc;
    assign new_label = pc_M + DATA_WIDTH'(4);
    assign flush     = error | (pcsrc & ~correct);

    // Training is held off while frozen so each branch trains once.
    assign wr_en = m_vld_q & ~miss;

    always_comb begin
        d_vld_d  = d_vld_q;
        e_vld_d  = e_vld_q;
        m_vld_d  = m_vld_q;
        d_pred_d = d_pred_q;
        e_pred_d = e_pred_q;
        m_pred_d = m_pred_q;
        d_idx_d  = d_idx_q;
        e_idx_d  = e_idx_q;
        m_idx_d  = m_idx_q;
        if (miss) begin
            d_vld_d = d_vld_q;
        end else if (flush) begin
            d_vld_d = 1'b0;
            e_vld_d = 1'b0;
            m_vld_d = 1'b0;
        end else if (load_use_flag) begin
            m_vld_d  = e_vld_q;
            m_pred_d = e_pred_q;
            m_idx_d  = e_idx_q;
            e_vld_d  = 1'b0;
        end else begin
            m_vld_d  = e_vld_q;
            m_pred_d = e_pred_q;
            m_idx_d  = e_idx_q;
            e_vld_d  = d_vld_q;
            e_pred_d = d_pred_q;
            e_idx_d  = d_idx_q;
            d_vld_d  = pre_branch;
            d_pred_d = prediction;
            d_idx_d  = if_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_vld_q  <= 1'b0;
            e_vld_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            d_pred_q <= 1'b0;
            e_pred_q <= 1'b0;
            m_pred_q <= 1'b0;
            d_idx_q  <= '0;
            e_idx_q  <= '0;
            m_idx_q  <= '0;
        end else begin
            d_vld_q  <= d_vld_d;
            e_vld_q  <= e_vld_d;
            m_vld_q  <= m_vld_d;
            d_pred_q <= d_pred_d;
            e_pred_q <= e_pred_d;
            m_pred_q <= m_pred_d;
            d_idx_q  <= d_idx_d;
            e_idx_q  <= e_idx_d;
            m_idx_q  <= m_idx_d;
        end
    end

    bp_counter_table #(
        .IDX_BITS(IDX_BITS)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (if_idx),
        .rd_cnt  (rd_cnt),
        .wr_en   (wr_en),
        .wr_idx  (m_idx_q),
        .wr_taken(pcsrc)
    );

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor directly upstream of the pipelined RV32I core. It decodes the instruction being fetched, predicts conditional branches with a table of 2-bit saturating counters, and supplies the predicted target. It tracks each prediction down to the MEM stage, where the core resolves the branch. At resolution it reports whether the prediction was correct or wrong, and trains the counter.

## Interface
- DATA_WIDTH, 32, datapath width
- IDX_BITS, 6, log2 of counter-table depth (64 entries)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous and active-high
- pc  in  DATA_WIDTH  fetch PC
- instr  in  DATA_WIDTH  instruction at fetch PC
- pc_M  in  DATA_WIDTH  PC of instruction in MEM
- pcsrc  in  1  branch in MEM actually taken
- load_use_flag  in  1  IF/ID hold, bubble into EX
- miss  in  1  data-cache miss, whole pipeline frozen
- pre_branch  out  1  fetched instr is conditional branch (opcode 1100011)
- prediction  out  1  predicted taken; 0 when pre_branch=0
- label  out  DATA_WIDTH  pc + B-immediate (sign-extended, bit0=0)
- correct  out  1  branch in MEM resolved with matching prediction
- error  out  1  branch in MEM predicted taken, actually not taken
- new_label  out  DATA_WIDTH  recovery PC, pc_M + 4

## Operation
- Counter states: SNT=00, WNT=01, WT=10, ST=11; prediction = counter[1] & pre_branch.
- Index = pc[IDX_BITS+1:2]; table read is combinational.
- Tracking queue of three entries D, E, M, each {valid, pred, idx}; IF entry = {pre_branch, prediction, index}.
- Queue advance priority, evaluated each edge:
  - rst: all entries invalid, all counters WNT.
  - miss: all entries hold; this takes precedence over flush and load_use_flag.
  - flush, defined as error | (pcsrc & ~correct): D, E, M all invalid.
  - load_use_flag: D holds, E becomes invalid, M takes E.
  - otherwise: M takes E, E takes D, D takes IF.
- Resolution at M when M.valid:
  - correct = (M.pred == pcsrc).
  - error = M.pred & ~pcsrc.
  - new_label = pc_M + 4.
  - When M is invalid, correct = error = 0.
- Predicted-not-taken but actually taken gives correct=0, error=0. The core redirects through pcsrc.
- Training: the counter at M.idx is incremented (pcsrc=1) or decremented (pcsrc=0), saturating at 11/00. It is written only when M.valid & ~miss, so each branch trains exactly once.
- Arithmetic: label and new_label are modulo 2^DATA_WIDTH.

## Timing
- pre_branch, prediction and label are combinational from pc/instr in the same cycle.
- correct, error and new_label are combinational from the M entry and pcsrc/pc_M.
- Prediction-to-resolution latency is 3 unstalled cycles.
- Counter write takes effect at the edge. A same-cycle read of the index being written returns the old value; there is no bypass.
- Reset values: all queue entries invalid, so correct=0 and error=0 the cycle after rst. Fetch-side outputs follow pc/instr immediately.
- Reset asserted mid-operation discards in-flight branches with no training.
- miss asserted with a valid M: correct/error stay asserted for every frozen cycle, but training happens once, on the first cycle with miss=0.

## Configuration
- GSHARE_PREDICTOR_EN defined:
  - Adds an IDX_BITS-wide global history register, reset to 0.
  - Index = pc[IDX_BITS+1:2] ^ ghr.
  - At each training write, ghr shifts left with pcsrc entering bit 0.
  - The stored idx is used for training, so the history does not re-index the write.
- Not defined: no ghr, and index is pc bits only.

## Structure
- Shared package (riscv_pkg): OPC_BRANCH = 7'b1100011, counter state constants, reset counter value WNT, B-immediate extraction function.
- One sub-module: bp_counter_table, holding the 2^IDX_BITS×2 array, async read port, sync saturating-update port and sync reset.
- Queue, decode and resolution logic live in branch_predictor.

## Test plan
- Reset, then fetch pc=0x40, instr=0x00208463 (beq x1,x2,+8) -> pre_branch=1, prediction=0, label=0x48.
- Same beq resolved taken twice (pc_M=0x40, pcsrc=1 at M) -> first resolve correct=0, error=0; refetch at 0x40 after the second resolve gives prediction=1.
- Counter at ST, branch resolves not taken -> error=1, new_label=0x44, queue flushed next cycle, counter becomes WT.
- miss held 4 cycles with a valid M entry -> correct held for 4 cycles, counter changes by exactly one step.
- load_use_flag for 1 cycle with a branch in D -> E receives bubble, branch reaches M one cycle later and resolves normally.
- With GSHARE_PREDICTOR_EN, ghr=0b000011 and pc=0x40 -> table index 0x10^0x03=0x13 read and later trained.
